// File: rtl/harp_tone_gen.sv
// Harp tone generator: one gated square-wave oscillator per string, summed into a
// signed sample that is offered to the codec once per sample period over valid/ready.
module harp_tone_gen #(
  parameter int NUM_CH     = 8,
  parameter int HDC_W      = 20,
  parameter int AMP        = 1000000,
  parameter int SAMPLE_DIV = 1042,
  parameter int OUT_W      = 24
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH*HDC_W-1:0] hdc_in,
  input  logic [NUM_CH-1:0]       gate,
  input  logic                    sample_ready,
  output logic signed [OUT_W-1:0] sample_data,
  output logic                    sample_valid,
  output logic                    overrun,
  output logic [NUM_CH-1:0]       tone_out
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} ch_state_e;

  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam logic signed [OUT_W-1:0] AMP_P = OUT_W'(AMP);
  localparam logic signed [OUT_W-1:0] AMP_N = OUT_W'(-AMP);

  ch_state_e                state_q   [NUM_CH];
  ch_state_e                state_d   [NUM_CH];
  logic [HDC_W-1:0]         cnt_q     [NUM_CH];
  logic [HDC_W-1:0]         cnt_d     [NUM_CH];
  logic [HDC_W-1:0]         hdc_act_q [NUM_CH];
  logic [HDC_W-1:0]         hdc_act_d [NUM_CH];
  logic [NUM_CH-1:0]        phase_q, phase_d;
  logic [NUM_CH-1:0]        gate_q, gate_d;
  logic [DIV_W-1:0]         div_q, div_d;
  logic signed [OUT_W-1:0]  sample_q, sample_d;
  logic signed [OUT_W-1:0]  mix;
  logic                     valid_q, valid_d;
  logic                     overrun_q, overrun_d;
  logic                     strobe;

  // A half period shorter than 2 cycles would leave no room for the counter to advance.
  function automatic logic [HDC_W-1:0] clamp_hdc(input logic [HDC_W-1:0] x);
    return (x < HDC_W'(2)) ? HDC_W'(2) : x;
  endfunction

  always_comb begin
    gate_d = gate;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i]   = state_q[i];
      cnt_d[i]     = cnt_q[i];
      hdc_act_d[i] = hdc_act_q[i];
      phase_d[i]   = phase_q[i];
      if (state_q[i] == IDLE) begin
        cnt_d[i]   = '0;
        phase_d[i] = 1'b1;
        if (gate[i] && !gate_q[i]) begin
          hdc_act_d[i] = clamp_hdc(hdc_in[i*HDC_W +: HDC_W]);
          state_d[i]   = RUN;
        end
      end else if (!gate[i]) begin
        // Releasing the string wins over a toggle due in the same cycle.
        state_d[i] = IDLE;
        cnt_d[i]   = '0;
        phase_d[i] = 1'b1;
      end else if (cnt_q[i] == hdc_act_q[i] - HDC_W'(1)) begin
        // New pitch is picked up only here, so no half-cycle is ever truncated.
        cnt_d[i]     = '0;
        phase_d[i]   = ~phase_q[i];
        hdc_act_d[i] = clamp_hdc(hdc_in[i*HDC_W +: HDC_W]);
      end else begin
        cnt_d[i] = cnt_q[i] + HDC_W'(1);
      end
    end
  end

  always_comb begin
    mix      = '0;
    tone_out = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (state_q[i] == RUN) begin
        mix         = mix + (phase_q[i] ? AMP_P : AMP_N);
        tone_out[i] = phase_q[i];
      end
    end
  end

  always_comb begin
    strobe    = (div_q == DIV_W'(SAMPLE_DIV - 1));
    div_d     = strobe ? '0 : div_q + DIV_W'(1);
    sample_d  = sample_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (strobe) begin
      sample_d = mix;
      valid_d  = 1'b1;
      if (valid_q && !sample_ready) overrun_d = 1'b1;
    end else if (valid_q && sample_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]   <= IDLE;
        cnt_q[i]     <= '0;
        hdc_act_q[i] <= '0;
      end
      phase_q   <= '1;
      gate_q    <= '0;
      div_q     <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]   <= state_d[i];
        cnt_q[i]     <= cnt_d[i];
        hdc_act_q[i] <= hdc_act_d[i];
      end
      phase_q   <= phase_d;
      gate_q    <= gate_d;
      div_q     <= div_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign sample_data  = sample_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_harp_tone_gen.sv
// Bench for harp_tone_gen: directed gate/pitch scenarios; mixed samples are
// checked by a queue-fed monitor, tone timing and handshake flags inline.
`timescale 1ns/1ps
module tb_harp_tone_gen;

  localparam int NUM_CH     = 8;
  localparam int HDC_W      = 20;
  localparam int AMP        = 1000000;
  localparam int SAMPLE_DIV = 1042;
  localparam int OUT_W      = 24;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NUM_CH*HDC_W-1:0] hdc_in;
  logic [NUM_CH-1:0]       gate;
  logic                    sample_ready;
  logic signed [OUT_W-1:0] sample_data;
  logic                    sample_valid;
  logic                    overrun;
  logic [NUM_CH-1:0]       tone_out;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint exp_q[$];

  harp_tone_gen #(
    .NUM_CH(NUM_CH), .HDC_W(HDC_W), .AMP(AMP), .SAMPLE_DIV(SAMPLE_DIV), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .reset(reset), .hdc_in(hdc_in), .gate(gate), .sample_ready(sample_ready),
    .sample_data(sample_data), .sample_valid(sample_valid), .overrun(overrun),
    .tone_out(tone_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_hdc(input int ch, input int v);
    hdc_in[ch*HDC_W +: HDC_W] = HDC_W'(v);
  endtask

  task automatic drop_gates();
    gate = '0;
    step();
    step();
  endtask

  // Returns just after a sample transfer, so the next strobe is a full period away.
  task automatic sync_sample();
    int n = 0;
    @(negedge clk);
    while (!(sample_valid && sample_ready) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("sync_timeout", n, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      step();
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic measure(input int ch, input logic level, input int exp, input string name);
    int n = 0;
    while (tone_out[ch] == level && n < exp + 10) begin
      step();
      n++;
    end
    chk(name, n, exp);
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    while (!sample_valid && n < limit) begin
      step();
      n++;
    end
  endtask

  always @(negedge clk) begin
    if (!reset && sample_valid && sample_ready && exp_q.size() > 0) begin
      longint e;
      e = exp_q.pop_front();
      chk("sample", longint'(sample_data), e);
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset        = 1'b1;
    gate         = '0;
    hdc_in       = '0;
    sample_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tone", tone_out, 0);
    chk("rst_data", longint'(sample_data), 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_overrun", overrun, 0);
    reset = 1'b0;

    // Single string C sounding: one cycle latency, +AMP in the mix
    set_hdc(0, 95556);
    gate = 8'h01;
    chk("tone0_pre", tone_out[0], 0);
    step();
    chk("tone0_rise", tone_out[0], 1);
    sync_sample();
    exp_q.push_back(1000000);
    drain();

    // All strings together, then the fast half flipped low
    drop_gates();
    for (int i = 0; i < 4; i++) set_hdc(i, 6000);
    for (int i = 4; i < 8; i++) set_hdc(i, 95556);
    gate = 8'hFF;
    step();
    chk("all_tone", tone_out, 8'hFF);
    sync_sample();
    exp_q.push_back(8000000);
    drain();
    repeat (6000) step();
    chk("half_tone", tone_out, 8'hF0);
    sync_sample();
    exp_q.push_back(0);
    drain();

    // Pitch change mid half-period waits for the toggle boundary
    drop_gates();
    set_hdc(0, 100);
    gate = 8'h01;
    step();
    chk("chg_rise", tone_out[0], 1);
    repeat (30) step();
    set_hdc(0, 50);
    measure(0, 1'b1, 70, "chg_first_high");
    measure(0, 1'b0, 50, "chg_low");
    measure(0, 1'b1, 50, "chg_high");

    // Degenerate counts clamp to a 2-cycle half period
    drop_gates();
    set_hdc(3, 0);
    gate = 8'h08;
    step();
    chk("clamp_rise", tone_out[3], 1);
    measure(3, 1'b1, 2, "clamp0_high");
    measure(3, 1'b0, 2, "clamp0_low");
    set_hdc(3, 1);
    measure(3, 1'b1, 2, "clamp1_high");
    measure(3, 1'b0, 2, "clamp1_low");
    measure(3, 1'b1, 2, "clamp1_high2");

    // Codec stalls across two strobes
    drop_gates();
    set_hdc(1, 95556);
    set_hdc(2, 95556);
    set_hdc(5, 95556);
    gate = 8'h02;
    sync_sample();
    sample_ready = 1'b0;
    wait_valid(1100, n);
    chk("ovr_first_valid", sample_valid, 1);
    chk("ovr_first_data", longint'(sample_data), 1000000);
    chk("ovr_first_flag", overrun, 0);
    gate = 8'h06;
    n = 0;
    while (sample_data == 1000000 && n < 1100) begin
      step();
      n++;
    end
    chk("ovr_second_data", longint'(sample_data), 2000000);
    chk("ovr_second_valid", sample_valid, 1);
    chk("ovr_flag", overrun, 1);
    repeat (5) step();
    chk("ovr_sticky", overrun, 1);
    exp_q.push_back(2000000);
    sample_ready = 1'b1;
    step();
    sample_ready = 1'b0;
    chk("ovr_valid_drop", sample_valid, 0);
    chk("ovr_popped", exp_q.size(), 0);

    // Reset with three strings running and a sample pending
    gate = 8'h26;
    wait_valid(1100, n);
    chk("pre_rst_valid", sample_valid, 1);
    chk("pre_rst_tone", tone_out, 8'h26);
    reset = 1'b1;
    gate  = '0;
    step();
    reset = 1'b0;
    chk("mid_rst_tone", tone_out, 0);
    chk("mid_rst_data", longint'(sample_data), 0);
    chk("mid_rst_valid", sample_valid, 0);
    chk("mid_rst_overrun", overrun, 0);
    wait_valid(1100, n);
    chk("div_restart", n, SAMPLE_DIV);
    chk("post_rst_data", longint'(sample_data), 0);
    chk("post_rst_tone", tone_out, 0);
    exp_q.push_back(0);
    sample_ready = 1'b1;
    set_hdc(6, 95556);
    gate = 8'h40;
    step();
    chk("resume_tone", tone_out, 8'h40);
    sync_sample();
    exp_q.push_back(1000000);
    drain();

    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
